// File: rtl/timedisk_pkg.sv
// Shared definitions for the ramdisk SRAM arbiter: register map, control bits,
// engine FSM encoding and the engine-to-pin control payload.
package timedisk_pkg;

  localparam logic [2:0] SEL_ADDRL = 3'd0;
  localparam logic [2:0] SEL_ADDRM = 3'd1;
  localparam logic [2:0] SEL_ADDRH = 3'd2;
  localparam logic [2:0] SEL_LENL  = 3'd3;
  localparam logic [2:0] SEL_LENM  = 3'd4;
  localparam logic [2:0] SEL_LENH  = 3'd5;
  localparam logic [2:0] SEL_FILL  = 3'd6;
  localparam logic [2:0] SEL_CTRL  = 3'd7;

  localparam int unsigned CTRL_GO    = 0;
  localparam int unsigned CTRL_MODE  = 1;
  localparam int unsigned CTRL_ABORT = 2;

  localparam int unsigned STAT_MODE = 1;
  localparam int unsigned STAT_COLL = 5;
  localparam int unsigned STAT_DONE = 6;
  localparam int unsigned STAT_BUSY = 7;

  // Addr/Len are exposed as three byte lanes
  localparam int unsigned CFG_W = 24;

  localparam logic [2:0] S_LAST = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } eng_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       oe;
    logic       we_n;
    logic       cs;
  } sram_ctl_t;

endpackage

// File: rtl/ram_fill_engine.sv
// Background fill/checksum engine: config registers, slot FSM and the
// Addr/Len/Sum counters. Moves one byte per bus cycle in the PHI1 slot.
module ram_fill_engine
  import timedisk_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned LEN_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        s,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_sel,
  input  logic [7:0]        cfg_d,
  input  logic [7:0]        rd_in,
  input  logic              coll_hit,
  output logic [7:0]        cfg_q_c,
  output logic [ADDR_W-1:0] eng_addr,
  output sram_ctl_t         eng_ctl_c,
  output logic              eng_slot_c,
  output logic              busy,
  output logic              done
);

  eng_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [7:0]        fill_q, sum_q;
  logic              mode_q, coll_q, busy_q, done_q, abort_pend_q, abort_pend_d;
  logic [2:0]        s_prev_q;
  logic [CFG_W-1:0]  addr_ext_c, len_ext_c;
  logic              wr_ok_c, ctrl_wr_c, abort_c, go_c, start_c, slot_c, last_c;

  assign addr_ext_c = CFG_W'(addr_q);
  assign len_ext_c  = CFG_W'(len_q);

  // While busy only an ABORT control write gets through
  assign wr_ok_c   = cfg_wr && (!busy_q || (cfg_sel == SEL_CTRL && cfg_d[CTRL_ABORT]));
  assign ctrl_wr_c = wr_ok_c && (cfg_sel == SEL_CTRL);
  assign abort_c   = ctrl_wr_c && cfg_d[CTRL_ABORT];
  assign go_c      = ctrl_wr_c && cfg_d[CTRL_GO] && !cfg_d[CTRL_ABORT];
  assign start_c   = go_c && (len_q != '0);
  assign slot_c    = (s == S_LAST) && (s_prev_q != S_LAST);
  assign last_c    = (len_q == LEN_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state; a bus collision sends the byte back to ARM for a retry
  always_comb begin
    state_d      = state_q;
    abort_pend_d = abort_pend_q;
    case (state_q)
      ST_IDLE:   if (start_c) state_d = ST_ARM;
      ST_ARM:    if (abort_c || abort_pend_q) state_d = ST_IDLE;
                 else if (slot_c)             state_d = ST_SETUP;
      ST_SETUP:  state_d = coll_hit ? ST_ARM : ST_STROBE;
      ST_STROBE: state_d = coll_hit ? ST_ARM : ST_HOLD;
      ST_HOLD:   if (coll_hit)                              state_d = ST_ARM;
                 else if (last_c || abort_c || abort_pend_q) state_d = ST_IDLE;
                 else                                       state_d = ST_ARM;
      default:   state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE)               abort_pend_d = 1'b0;
    else if (abort_c && state_q != ST_IDLE) abort_pend_d = 1'b1;
  end

  // SRAM control decoded from state
  always_comb begin
    eng_slot_c     = 1'b0;
    eng_ctl_c.cs   = 1'b0;
    eng_ctl_c.we_n = 1'b1;
    eng_ctl_c.oe   = 1'b0;
    eng_ctl_c.data = fill_q;
    if (state_q == ST_SETUP || state_q == ST_STROBE || state_q == ST_HOLD) begin
      eng_slot_c   = 1'b1;
      eng_ctl_c.cs = 1'b1;
      eng_ctl_c.oe = !mode_q;
    end
    if (state_q == ST_STROBE && !mode_q) eng_ctl_c.we_n = 1'b0;
  end

  // Config registers, status flags and transfer counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev_q     <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      fill_q       <= '0;
      sum_q        <= '0;
      mode_q       <= 1'b0;
      coll_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      s_prev_q     <= s;
      busy_q       <= (state_d != ST_IDLE);
      abort_pend_q <= abort_pend_d;
      if (wr_ok_c && !busy_q) begin
        case (cfg_sel)
          SEL_ADDRL: addr_q <= ADDR_W'({addr_ext_c[23:8], cfg_d});
          SEL_ADDRM: addr_q <= ADDR_W'({addr_ext_c[23:16], cfg_d, addr_ext_c[7:0]});
          SEL_ADDRH: addr_q <= ADDR_W'({cfg_d, addr_ext_c[15:0]});
          SEL_LENL:  len_q  <= LEN_W'({len_ext_c[23:8], cfg_d});
          SEL_LENM:  len_q  <= LEN_W'({len_ext_c[23:16], cfg_d, len_ext_c[7:0]});
          SEL_LENH:  len_q  <= LEN_W'({cfg_d, len_ext_c[15:0]});
          SEL_FILL:  fill_q <= cfg_d;
          default:   mode_q <= cfg_d[CTRL_MODE];
        endcase
      end
      if (go_c) begin
        done_q <= !start_c;
        if (start_c) begin
          coll_q <= 1'b0;
          sum_q  <= '0;
        end
      end
      if (abort_c && state_q == ST_IDLE) done_q <= 1'b1;
      if (state_q != ST_IDLE && state_d == ST_IDLE) done_q <= 1'b1;
      if (coll_hit) coll_q <= 1'b1;
      if (state_q == ST_STROBE && !coll_hit && mode_q) sum_q <= sum_q + rd_in;
      if (state_q == ST_HOLD && !coll_hit) begin
        addr_q <= addr_q + ADDR_W'(1);
        len_q  <= len_q - LEN_W'(1);
      end
    end
  end

  // Register readback
  always_comb begin
    cfg_q_c = '0;
    case (cfg_sel)
      SEL_ADDRL: cfg_q_c = addr_ext_c[7:0];
      SEL_ADDRM: cfg_q_c = addr_ext_c[15:8];
      SEL_ADDRH: cfg_q_c = addr_ext_c[23:16];
      SEL_LENL:  cfg_q_c = len_ext_c[7:0];
      SEL_LENM:  cfg_q_c = len_ext_c[15:8];
      SEL_LENH:  cfg_q_c = len_ext_c[23:16];
      SEL_FILL:  cfg_q_c = mode_q ? sum_q : fill_q;
      default: begin
        cfg_q_c[STAT_BUSY] = busy_q;
        cfg_q_c[STAT_DONE] = done_q;
        cfg_q_c[STAT_COLL] = coll_q;
        cfg_q_c[STAT_MODE] = mode_q;
      end
    endcase
  end

  assign eng_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: rtl/ram_access_arbiter.sv
// Ramdisk SRAM arbiter: Apple II bus accesses pass straight through and always
// override the background engine, which is told when it lost its slot.
module ram_access_arbiter
  import timedisk_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned LEN_W  = 20
) (
  input  logic              C7M,
  input  logic              RES,
  input  logic [2:0]        S,
  input  logic              CfgWR,
  input  logic [2:0]        CfgSel,
  input  logic [7:0]        CfgD,
  output logic [7:0]        CfgQ,
  input  logic              BusRAMCS,
  input  logic [ADDR_W-1:0] BusAddr,
  input  logic              BusnWE,
  input  logic [7:0]        BusD,
  input  logic [7:0]        RDin,
  output logic [7:0]        RDout,
  output logic              RDOE,
  output logic [ADDR_W-1:0] RA,
  output logic              RAMCS,
  output logic              nRAMWE,
  output logic              Busy,
  output logic              Done
);

  logic [ADDR_W-1:0] eng_addr;
  sram_ctl_t         eng_ctl_c;
  logic              eng_slot_c, coll_hit_c;

  assign coll_hit_c = BusRAMCS && eng_slot_c;

  ram_fill_engine #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_engine (
    .clk       (C7M),
    .rst       (RES),
    .s         (S),
    .cfg_wr    (CfgWR),
    .cfg_sel   (CfgSel),
    .cfg_d     (CfgD),
    .rd_in     (RDin),
    .coll_hit  (coll_hit_c),
    .cfg_q_c   (CfgQ),
    .eng_addr  (eng_addr),
    .eng_ctl_c (eng_ctl_c),
    .eng_slot_c(eng_slot_c),
    .busy      (Busy),
    .done      (Done)
  );

  // Bus-priority pin mux
  always_comb begin
    RA     = eng_addr;
    RAMCS  = eng_ctl_c.cs;
    nRAMWE = eng_ctl_c.we_n;
    RDout  = eng_ctl_c.data;
    RDOE   = eng_ctl_c.oe;
    if (BusRAMCS) begin
      RA     = BusAddr;
      RAMCS  = 1'b1;
      nRAMWE = BusnWE;
      RDout  = BusD;
      RDOE   = !BusnWE;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: table-driven bus/register vectors plus
// hand-written fill, wrap, sum, collision, abort and reset sequences.
module tb_ram_access_arbiter;

  logic        C7M = 1'b0;
  logic        RES;
  logic [2:0]  S;
  logic        CfgWR;
  logic [2:0]  CfgSel;
  logic [7:0]  CfgD;
  logic [7:0]  CfgQ;
  logic        BusRAMCS;
  logic [19:0] BusAddr;
  logic        BusnWE;
  logic [7:0]  BusD;
  logic [7:0]  RDin;
  logic [7:0]  RDout;
  logic        RDOE;
  logic [19:0] RA;
  logic        RAMCS;
  logic        nRAMWE;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  assign RDin = mem[RA[7:0]];

  ram_access_arbiter #(.ADDR_W(20), .LEN_W(20)) dut (
    .C7M(C7M), .RES(RES), .S(S), .CfgWR(CfgWR), .CfgSel(CfgSel), .CfgD(CfgD),
    .CfgQ(CfgQ), .BusRAMCS(BusRAMCS), .BusAddr(BusAddr), .BusnWE(BusnWE),
    .BusD(BusD), .RDin(RDin), .RDout(RDout), .RDOE(RDOE), .RA(RA),
    .RAMCS(RAMCS), .nRAMWE(nRAMWE), .Busy(Busy), .Done(Done)
  );

  always #5 C7M = ~C7M;

  // Phase counter: 1..7 then back to 1, one step per C7M cycle
  initial begin
    S = 3'd1;
    forever begin
      @(posedge C7M);
      #1;
      S = (S == 3'd7) ? 3'd1 : S + 3'd1;
    end
  end

  // Engine write monitor (bus-driven writes excluded)
  logic [19:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [2:0]  wr_s_q    [$];
  time         wr_t_q    [$];
  int          cs_rise = 0;
  int          nwe_low = 0;
  logic        cs_prev = 1'b0;
  always @(negedge C7M) begin
    if (RAMCS && !nRAMWE && !BusRAMCS) begin
      wr_addr_q.push_back(RA);
      wr_data_q.push_back(RDout);
      wr_s_q.push_back(S);
      wr_t_q.push_back($time);
    end
    if (!nRAMWE) nwe_low <= nwe_low + 1;
    if (RAMCS && !cs_prev) cs_rise <= cs_rise + 1;
    cs_prev <= RAMCS;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge C7M);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [7:0] d);
    CfgSel = sel;
    CfgD   = d;
    CfgWR  = 1'b1;
    tick();
    CfgWR  = 1'b0;
  endtask

  task automatic cfg_read(input logic [2:0] sel, output logic [7:0] q);
    CfgSel = sel;
    #1;
    q = CfgQ;
  endtask

  task automatic check_reg(input string name, input logic [2:0] sel, input logic [7:0] exp);
    logic [7:0] q;
    cfg_read(sel, q);
    check(name, 32'(q), 32'(exp));
  endtask

  task automatic setup_xfer(input logic [19:0] a, input logic [19:0] n, input logic [7:0] f);
    cfg_write(3'd0, a[7:0]);
    cfg_write(3'd1, a[15:8]);
    cfg_write(3'd2, {4'h0, a[19:16]});
    cfg_write(3'd3, n[7:0]);
    cfg_write(3'd4, n[15:8]);
    cfg_write(3'd5, {4'h0, n[19:16]});
    cfg_write(3'd6, f);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (Busy && n < 600) begin
      tick();
      n++;
    end
    check({name, " finished"}, 32'(Busy), 32'd0);
  endtask

  // Returns #1 into the SETUP state of the nth slot after the call
  task automatic wait_setup(input string name, input int nth);
    int   seen;
    int   n;
    logic prev;
    seen = 0;
    n    = 0;
    prev = RAMCS;
    while (seen < nth && n < 400) begin
      tick();
      n++;
      if (RAMCS && !prev) seen++;
      prev = RAMCS;
    end
    check({name, " slot reached"}, 32'(seen), 32'(nth));
  endtask

  typedef struct {
    logic        cs;
    logic [19:0] addr;
    logic        nwe;
    logic [7:0]  d;
    logic [19:0] e_ra;
    logic        e_cs;
    logic        e_nwe;
    logic        e_oe;
    logic [7:0]  e_rd;
  } bus_vec_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] d;
    logic [7:0] e_q;
  } reg_vec_t;

  bus_vec_t bus_tab [4];
  reg_vec_t reg_tab [7];

  initial begin
    int  base, cs_base, nwe_base, busy_hi;
    time tc;

    bus_tab[0] = '{1'b1, 20'h12345, 1'b0, 8'h5A, 20'h12345, 1'b1, 1'b0, 1'b1, 8'h5A};
    bus_tab[1] = '{1'b1, 20'hFFFFF, 1'b1, 8'h00, 20'hFFFFF, 1'b1, 1'b1, 1'b0, 8'h00};
    bus_tab[2] = '{1'b0, 20'h00ABC, 1'b0, 8'h77, 20'h00000, 1'b0, 1'b1, 1'b0, 8'h00};
    bus_tab[3] = '{1'b1, 20'h00000, 1'b0, 8'hFF, 20'h00000, 1'b1, 1'b0, 1'b1, 8'hFF};

    reg_tab[0] = '{3'd0, 8'h34, 8'h34};
    reg_tab[1] = '{3'd1, 8'h12, 8'h12};
    reg_tab[2] = '{3'd2, 8'hF7, 8'h07};
    reg_tab[3] = '{3'd3, 8'hCD, 8'hCD};
    reg_tab[4] = '{3'd4, 8'hAB, 8'hAB};
    reg_tab[5] = '{3'd5, 8'h9E, 8'h0E};
    reg_tab[6] = '{3'd6, 8'h5A, 8'h5A};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h01;
    mem[1] = 8'h02;
    mem[2] = 8'hFF;

    RES = 1'b1; CfgWR = 1'b0; CfgSel = 3'd0; CfgD = 8'h00;
    BusRAMCS = 1'b0; BusAddr = '0; BusnWE = 1'b1; BusD = 8'h00;
    repeat (3) tick();
    check("reset RAMCS", 32'(RAMCS), 32'd0);
    check("reset nRAMWE", 32'(nRAMWE), 32'd1);
    check("reset RDOE", 32'(RDOE), 32'd0);
    check("reset Busy", 32'(Busy), 32'd0);
    check("reset Done", 32'(Done), 32'd0);
    check_reg("reset ctrl", 3'd7, 8'h00);
    RES = 1'b0;
    tick();

    // Bus pass-through with the engine idle
    for (int i = 0; i < 4; i++) begin
      BusRAMCS = bus_tab[i].cs;
      BusAddr  = bus_tab[i].addr;
      BusnWE   = bus_tab[i].nwe;
      BusD     = bus_tab[i].d;
      #1;
      check($sformatf("bus[%0d] RAMCS", i), 32'(RAMCS), 32'(bus_tab[i].e_cs));
      check($sformatf("bus[%0d] nRAMWE", i), 32'(nRAMWE), 32'(bus_tab[i].e_nwe));
      check($sformatf("bus[%0d] RDOE", i), 32'(RDOE), 32'(bus_tab[i].e_oe));
      if (bus_tab[i].e_cs) begin
        check($sformatf("bus[%0d] RA", i), 32'(RA), 32'(bus_tab[i].e_ra));
        check($sformatf("bus[%0d] RDout", i), 32'(RDout), 32'(bus_tab[i].e_rd));
      end
    end
    BusRAMCS = 1'b0; BusnWE = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      cfg_write(reg_tab[i].sel, reg_tab[i].d);
      check_reg($sformatf("reg[%0d] readback", i), reg_tab[i].sel, reg_tab[i].e_q);
    end
    check_reg("ctrl idle", 3'd7, 8'h00);

    // Len=0 GO: Done on the same edge, no SRAM access
    cfg_write(3'd3, 8'h00);
    cfg_write(3'd4, 8'h00);
    cfg_write(3'd5, 8'h00);
    check("len0 Done before", 32'(Done), 32'd0);
    cs_base = cs_rise;
    cfg_write(3'd7, 8'h01);
    check("len0 Done", 32'(Done), 32'd1);
    busy_hi = 0;
    repeat (14) begin
      if (Busy) busy_hi++;
      tick();
    end
    check("len0 Busy never", 32'(busy_hi), 32'd0);
    check("len0 no RAMCS", 32'(cs_rise - cs_base), 32'd0);

    // GO and ABORT together: ABORT wins, nothing starts
    cfg_write(3'd3, 8'h02);
    cs_base = cs_rise;
    cfg_write(3'd7, 8'h05);
    check("go+abort Busy", 32'(Busy), 32'd0);
    repeat (14) tick();
    check("go+abort no RAMCS", 32'(cs_rise - cs_base), 32'd0);
    check_reg("go+abort len kept", 3'd3, 8'h02);

    // Fill basic
    setup_xfer(20'h12345, 20'd4, 8'hA5);
    base = wr_addr_q.size();
    cfg_write(3'd7, 8'h01);
    check("fill Busy", 32'(Busy), 32'd1);
    check("fill Done cleared", 32'(Done), 32'd0);
    wait_idle("fill");
    check("fill count", 32'(wr_addr_q.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < wr_addr_q.size()) begin
        check($sformatf("fill[%0d] addr", i), 32'(wr_addr_q[base+i]), 32'h12345 + 32'(i));
        check($sformatf("fill[%0d] data", i), 32'(wr_data_q[base+i]), 32'hA5);
        check($sformatf("fill[%0d] in S7..S3", i),
              32'(wr_s_q[base+i] == 3'd7 || wr_s_q[base+i] <= 3'd3), 32'd1);
        if (i > 0)
          check($sformatf("fill[%0d] spacing", i), 32'(wr_t_q[base+i] - wr_t_q[base+i-1]), 32'd70);
      end
    end
    check("fill Done", 32'(Done), 32'd1);
    check_reg("fill addrL", 3'd0, 8'h49);
    check_reg("fill addrM", 3'd1, 8'h23);
    check_reg("fill addrH", 3'd2, 8'h01);
    check_reg("fill lenL", 3'd3, 8'h00);
    check_reg("fill lenM", 3'd4, 8'h00);
    check_reg("fill lenH", 3'd5, 8'h00);
    check_reg("fill ctrl", 3'd7, 8'h40);
    tick();

    // Address wrap
    setup_xfer(20'hFFFFE, 20'd3, 8'h3C);
    base = wr_addr_q.size();
    cfg_write(3'd7, 8'h01);
    wait_idle("wrap");
    check("wrap count", 32'(wr_addr_q.size() - base), 32'd3);
    if (wr_addr_q.size() >= base + 3) begin
      check("wrap addr0", 32'(wr_addr_q[base]),   32'hFFFFE);
      check("wrap addr1", 32'(wr_addr_q[base+1]), 32'hFFFFF);
      check("wrap addr2", 32'(wr_addr_q[base+2]), 32'h00000);
    end
    check_reg("wrap addrL", 3'd0, 8'h01);
    check_reg("wrap addrM", 3'd1, 8'h00);
    check_reg("wrap addrH", 3'd2, 8'h00);
    tick();

    // Checksum mode over 0x01, 0x02, 0xFF
    setup_xfer(20'h00000, 20'd3, 8'h11);
    nwe_base = nwe_low;
    cfg_write(3'd7, 8'h03);
    wait_idle("sum");
    check("sum nRAMWE never low", 32'(nwe_low - nwe_base), 32'd0);
    check_reg("sum value", 3'd6, 8'h02);
    check_reg("sum ctrl", 3'd7, 8'h42);
    tick();

    // Bus collision during STROBE
    setup_xfer(20'h00100, 20'd2, 8'hC3);
    base = wr_addr_q.size();
    cfg_write(3'd7, 8'h01);
    wait_setup("coll", 1);
    tick();
    tc = $time;
    BusRAMCS = 1'b1; BusAddr = 20'h0ABCD; BusnWE = 1'b1; BusD = 8'h00;
    #1;
    check("coll RA", 32'(RA), 32'h0ABCD);
    check("coll RAMCS", 32'(RAMCS), 32'd1);
    check("coll nRAMWE", 32'(nRAMWE), 32'd1);
    check("coll RDOE", 32'(RDOE), 32'd0);
    tick();
    BusRAMCS = 1'b0;
    check_reg("coll ctrl busy", 3'd7, 8'hA0);
    wait_idle("coll");
    check("coll count", 32'(wr_addr_q.size() - base), 32'd2);
    if (wr_addr_q.size() >= base + 2) begin
      check("coll retry addr", 32'(wr_addr_q[base]), 32'h00100);
      check("coll retry next cycle", 32'(wr_t_q[base] - tc), 32'd74);
      check("coll addr1", 32'(wr_addr_q[base+1]), 32'h00101);
    end
    check_reg("coll ctrl done", 3'd7, 8'h60);
    check_reg("coll addrL", 3'd0, 8'h02);
    tick();

    // ABORT in STROBE of byte 2 of 5
    setup_xfer(20'h00200, 20'd5, 8'h96);
    base = wr_addr_q.size();
    cfg_write(3'd7, 8'h01);
    wait_setup("abort", 2);
    tick();
    CfgSel = 3'd7; CfgD = 8'h04; CfgWR = 1'b1;
    tick();
    CfgWR = 1'b0;
    check("abort HOLD Busy", 32'(Busy), 32'd1);
    tick();
    check("abort Busy", 32'(Busy), 32'd0);
    check("abort Done", 32'(Done), 32'd1);
    repeat (20) tick();
    check("abort count", 32'(wr_addr_q.size() - base), 32'd2);
    check_reg("abort lenL", 3'd3, 8'h03);
    check_reg("abort addrL", 3'd0, 8'h02);
    tick();

    // Asynchronous reset mid-STROBE
    setup_xfer(20'h00300, 20'd3, 8'h5A);
    cfg_write(3'd7, 8'h01);
    wait_setup("reset", 1);
    tick();
    check("pre-reset nRAMWE", 32'(nRAMWE), 32'd0);
    RES = 1'b1;
    #1;
    check("async RAMCS", 32'(RAMCS), 32'd0);
    check("async nRAMWE", 32'(nRAMWE), 32'd1);
    check("async RDOE", 32'(RDOE), 32'd0);
    check("async Busy", 32'(Busy), 32'd0);
    check_reg("async addrL", 3'd0, 8'h00);
    check_reg("async lenL", 3'd3, 8'h00);
    check_reg("async fill", 3'd6, 8'h00);
    check_reg("async ctrl", 3'd7, 8'h00);
    tick();
    RES = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
